// File: rtl/crank_cam_gen.sv
// crank_cam_gen: synthetic crank (60-2 style) tooth wheel and cam signal generator.
// Optional feature: define CRANK_CAM_GEN_ACCEL_EN to add a saturating per-tooth
// period ramp driven by the signed 'accel' input. Without it, 'accel' is ignored.
module crank_cam_gen #(
    parameter int TEETH   = 60,
    parameter int GAP     = 2,
    parameter int PER_W   = 16,
    parameter int CAM_ON  = 4,
    parameter int CAM_OFF = 54
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    input  logic [PER_W-1:0]         period,
    input  logic                     period_we,
    input  logic [PER_W-1:0]         accel,
    output logic                     vr,
    output logic                     cam,
    output logic [$clog2(TEETH)-1:0] tooth,
    output logic                     rev_stb,
    output logic                     cam_phase
);

    localparam int TW = $clog2(TEETH);
    // GAP+1 < 2**GW, so the longest tooth (GAP+1)*(2**PER_W-1) fits in CW bits
    localparam int GW = $clog2(GAP + 2);
    localparam int CW = PER_W + GW;
    localparam logic [TW-1:0] LAST_T    = TW'(TEETH - GAP - 1);
    localparam logic [TW-1:0] CAM_ON_T  = TW'(CAM_ON);
    localparam logic [TW-1:0] CAM_OFF_T = TW'(CAM_OFF);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [PER_W-1:0] p_q, p_d;
    logic [PER_W-1:0] req_q, req_d;
    logic [TW-1:0]    tooth_q, tooth_d;
    logic             cam_q, cam_d;
    logic             phase_q, phase_d;
    logic             stb_q, stb_d;
    logic             run_q, run_d;

    logic [PER_W-1:0] halfP;
    logic [PER_W-1:0] highLen;
    logic [CW-1:0]    toothLen;
    logic [CW-1:0]    lowLen;
    logic             isLast;
    logic             endOfTooth;
    logic             boundary;

    // Periods below 2 cannot produce both a low and a high phase
    function automatic logic [PER_W-1:0] clampP(input logic [PER_W-1:0] x);
        return (x < PER_W'(2)) ? PER_W'(2) : x;
    endfunction

    // Tooth geometry: the last tooth absorbs the missing teeth into its low phase
    always_comb begin
        halfP      = p_q >> 1;
        highLen    = p_q - halfP;
        isLast     = (tooth_q == LAST_T);
        toothLen   = isLast ? (CW'(p_q) * CW'(GAP + 1)) : CW'(p_q);
        lowLen     = toothLen - CW'(highLen);
        endOfTooth = (cnt_q == toothLen - CW'(1));
        boundary   = ena && (!run_q || endOfTooth);
    end

`ifdef CRANK_CAM_GEN_ACCEL_EN
    localparam logic signed [PER_W+1:0] SUM_MIN = (PER_W+2)'(2);
    localparam logic signed [PER_W+1:0] SUM_MAX = {2'b00, {PER_W{1'b1}}};
    logic signed [PER_W+1:0] accelSum;
    logic [PER_W-1:0]        accelReq;

    // Saturating period ramp, applied once per tooth boundary
    always_comb begin
        accelSum = $signed({2'b00, req_q}) + $signed({{2{accel[PER_W-1]}}, accel});
        if (accelSum < SUM_MIN) begin
            accelReq = PER_W'(2);
        end else if (accelSum > SUM_MAX) begin
            accelReq = '1;
        end else begin
            accelReq = accelSum[PER_W-1:0];
        end
    end
`else
    logic unused_accel;
    assign unused_accel = ^accel;
`endif

    // Next state: period latch, tooth sequencing, revolution parity and cam window
    always_comb begin
        cnt_d   = cnt_q;
        p_d     = p_q;
        req_d   = req_q;
        tooth_d = tooth_q;
        cam_d   = cam_q;
        phase_d = phase_q;
        stb_d   = 1'b0;
        run_d   = run_q;
        if (ena) begin
            if (period_we) begin
                req_d = period;
            end
`ifdef CRANK_CAM_GEN_ACCEL_EN
            else if (boundary) begin
                req_d = accelReq;
            end
`endif
            if (boundary) begin
                cnt_d = '0;
                p_d   = clampP(req_d);
                run_d = 1'b1;
                if (run_q) begin
                    if (isLast) begin
                        tooth_d = '0;
                        stb_d   = 1'b1;
                        phase_d = ~phase_q;
                    end else begin
                        tooth_d = tooth_q + TW'(1);
                    end
                    if (phase_d && (tooth_d == CAM_ON_T)) begin
                        cam_d = 1'b1;
                    end else if (phase_d && (tooth_d == CAM_OFF_T)) begin
                        cam_d = 1'b0;
                    end
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // State registers; reset wins over every other input
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            p_q     <= PER_W'(2);
            req_q   <= PER_W'(2);
            tooth_q <= '0;
            cam_q   <= 1'b0;
            phase_q <= 1'b0;
            stb_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            req_q   <= req_d;
            tooth_q <= tooth_d;
            cam_q   <= cam_d;
            phase_q <= phase_d;
            stb_q   <= stb_d;
            run_q   <= run_d;
        end
    end

    assign vr        = (cnt_q >= lowLen);
    assign cam       = cam_q;
    assign tooth     = tooth_q;
    assign rev_stb   = stb_q;
    assign cam_phase = phase_q;

endmodule

// File: doc/crank_cam_gen.md
CRANK_CAM_GEN -- requirements
Module: crank_cam_gen

Interface
REQ-001 SHALL have parameter TEETH, default 60, meaning tooth positions per revolution, missing teeth included.
REQ-002 SHALL have parameter GAP, default 2, meaning missing teeth, with 1 <= GAP <= TEETH-3.
REQ-003 SHALL have parameter PER_W, default 16, meaning width of the tooth period in clk cycles.
REQ-004 SHALL have parameter CAM_ON, default 4, meaning the tooth index where cam rises.
REQ-005 SHALL have parameter CAM_OFF, default 54, meaning the tooth index where cam falls.
REQ-006 SHALL have port clk  in  1  system clock; all logic is on its rising edge.
REQ-007 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-008 SHALL have port ena  in  1  run enable; while low, all state holds.
REQ-009 SHALL have port period  in  PER_W  requested tooth period in clk cycles.
REQ-010 SHALL have port period_we  in  1  strobe that latches period into period_req.
REQ-011 SHALL have port accel  in  PER_W  signed period delta applied per tooth.
REQ-012 SHALL have port vr  out  1  crank tooth signal.
REQ-013 SHALL have port cam  out  1  cam signal, one window per 720 degrees.
REQ-014 SHALL have port tooth  out  clog2(TEETH)  current tooth index, 0..TEETH-GAP-1.
REQ-015 SHALL have port rev_stb  out  1  one-cycle pulse at the start of tooth 0.
REQ-016 SHALL have port cam_phase  out  1  revolution parity.

Function
REQ-017 SHALL give each normal tooth a low phase of floor(P/2) cycles followed by a high phase of P-floor(P/2) cycles, where P is the active period.
REQ-018 SHALL give the last tooth (index TEETH-GAP-1) a low phase of GAP*P+floor(P/2) cycles and a high phase of P-floor(P/2) cycles.
REQ-019 SHALL drive vr low on the first cycle of every tooth and high on the first cycle of its high phase.
REQ-020 SHALL advance tooth by 1 at each tooth end and wrap TEETH-GAP-1 -> 0.
REQ-021 SHALL pulse rev_stb together with the wrap to tooth 0.
REQ-022 SHALL toggle cam_phase on every wrap to tooth 0.
REQ-023 SHALL set cam to 1 when tooth becomes CAM_ON with cam_phase=1, and to 0 when tooth becomes CAM_OFF with cam_phase=1; otherwise cam holds.
REQ-024 SHALL load P from period_req only at tooth boundaries; a period_we mid-tooth changes nothing until the next tooth.
REQ-025 SHALL clamp P to a minimum of 2; values 0 and 1 are treated as 2.
REQ-026 SHALL, when period_we and a tooth boundary occur in the same cycle, use the newly written period for the tooth that starts.
REQ-027 SHALL compute internal cycle counters wide enough for (GAP+1)*(2^PER_W-1) with no overflow.
REQ-028 SHALL, while ena=0, freeze the counters, tooth, vr and cam and hold rev_stb at 0; on ena returning high, resume from the frozen cycle.

Reset
REQ-029 SHALL on rst=1 set vr=0, cam=0, tooth=0, rev_stb=0, cam_phase=0, period_req=2 and the cycle counter to 0.
REQ-030 SHALL, when rst is asserted mid-tooth, take reset values on the next edge, with rst taking priority over ena, period_we and accel.
REQ-031 SHALL, after rst is released, start tooth 0 on the first enabled cycle without pulsing rev_stb.

Configuration
REQ-032 SHALL, with CRANK_CAM_GEN_ACCEL_EN defined, at each tooth boundary apply period_req <= sat(period_req + accel) in the range [2, 2^PER_W-1] and use the result as the next P; an explicit period_we in the same cycle overrides the accel update.
REQ-033 SHALL, with CRANK_CAM_GEN_ACCEL_EN undefined, ignore accel and keep the port present; period_req changes only through period_we.

Verification
REQ-034 SHALL be verified for: period=64, accel=0, defaults -> 57 teeth of 32 low/32 high, last tooth 160 low/32 high, rev_stb every 3840 cycles.
REQ-035 SHALL be verified for: period=64 for 2 revolutions -> cam rises at tooth 4 and falls at tooth 54 in the rev with cam_phase=1 only, so one cam window per 7680 cycles.
REQ-036 SHALL be verified for: period=5 -> tooth low 2/high 3; period=0 -> 1/1 cycles.
REQ-037 SHALL be verified for: ena low for 100 cycles mid-tooth -> vr, tooth and count frozen; the remaining tooth length is unchanged after resume.
REQ-038 SHALL be verified for: ACCEL_EN defined, period=100, accel=-10 -> P=90, 80, ..., then saturates at 2; with ACCEL_EN undefined, P stays 100.
REQ-039 SHALL be verified for: rst asserted at tooth 30 during vr=1 -> next cycle vr=0, tooth=0, cam=0, cam_phase=0, no rev_stb on restart.
